uart_tx_ctrl: RTL and testbench

UART transmit controller: accepts a parallel byte with a valid strobe, then sequences start, data, optional parity and stop phases. It produces the serial data bit, the parity bit and the 2-bit phase select that drive the registered 4:1 output mux (`MUX4x1`), which forms `TX_OUT`. It merges the TX FSM, the serializer and the parity generator into one block, one bit per `CLK` cycle (`CLK` is the bit-rate clock).

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_parity_calc.sv | 37 +++
 rtl/uart_tx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding and output-mux select codes.
package uart_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned MUX_W     = 2;

  // Output mux select codes, shared with MUX4x1 and the RX side
  localparam logic [MUX_W-1:0] MUX_START = 2'b00;
  localparam logic [MUX_W-1:0] MUX_STOP  = 2'b01;
  localparam logic [MUX_W-1:0] MUX_DATA  = 2'b10;
  localparam logic [MUX_W-1:0] MUX_PAR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Mux select driven while the FSM sits in a given state; idle and stop both hold the line high
  function automatic logic [MUX_W-1:0] mux_for_state(input tx_state_e st);
    logic [MUX_W-1:0] sel;
    sel = MUX_STOP;
    case (st)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      default:   sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity generator: captures even/odd parity of a word on load, holds it otherwise.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data,
  input  logic             PAR_TYP,
  input  logic             load,
  output logic             par_bit
);

  logic par_q;
  logic par_d;

  // Even parity is the XOR reduction; odd parity inverts it
  always_comb begin
    par_d = par_q;
    if (load) begin
      par_d = (^data) ^ PAR_TYP;
    end
  end

  // Parity register, cleared asynchronously
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_bit = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start / LSB-first data / optional parity / stop, one bit per CLK.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             ser_data,
  output logic             par_bit,
  output logic [MUX_W-1:0] mux_sel,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_en_q, par_en_d;
  logic [MUX_W-1:0] mux_sel_q, mux_sel_d;
  logic             busy_q, busy_d;
  logic             ser_data_q, ser_data_d;
  logic             load_c;

  // Next-state, datapath and next-output decode; outputs are derived from next registered values only
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    load_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          data_d   = P_DATA;
          par_en_d = PAR_EN;
          load_c   = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    mux_sel_d  = mux_for_state(state_d);
    busy_d     = (state_d != ST_IDLE);
    ser_data_d = (state_d == ST_DATA) ? data_d[cnt_d] : 1'b0;
  end

  // State, counter, latch and output registers; reset returns the line to idle immediately
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      mux_sel_q  <= MUX_STOP;
      busy_q     <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      mux_sel_q  <= mux_sel_d;
      busy_q     <= busy_d;
      ser_data_q <= ser_data_d;
    end
  end

  // Parity is computed from the word being accepted so it is valid from the START cycle onward
  uart_parity_calc #(
    .WIDTH(WIDTH)
  ) u_parity (
    .CLK     (CLK),
    .RST     (RST),
    .data    (P_DATA),
    .PAR_TYP (PAR_TYP),
    .load    (load_c),
    .par_bit (par_bit)
  );

  assign mux_sel  = mux_sel_q;
  assign busy     = busy_q;
  assign ser_data = ser_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (WIDTH = 8).
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         ser_data;
  logic         par_bit;
  logic [1:0]   mux_sel;
  logic         busy;

  int vec_cnt;
  int err_cnt;

  uart_tx_ctrl #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected mux select at cycle c after acceptance (c=0 is START)
  function automatic logic [1:0] exp_mux(input int c, input logic pe);
    if (c == 0) return 2'b00;
    if (c >= 1 && c <= W) return 2'b10;
    if (pe && c == W + 1) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic exp_busy(input int c, input logic pe);
    return (c < W + 2 + int'(pe));
  endfunction

  // One-cycle DATA_VALID pulse; returns just after the accepting edge
  task automatic launch(input logic [W-1:0] d, input logic pe, input logic pt);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #12;
    vec_cnt++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: mux=%b busy=%b ser=%b par=%b, want 01 0 0 0", mux_sel, busy, ser_data, par_bit);
    end
    @(negedge CLK); RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      vec_cnt++;
      if (mux_sel !== 2'b01 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_idle c=%0d: mux=%b busy=%b, want 01 0", c, mux_sel, busy);
      end
    end
  endtask

  task automatic test_even_parity();
    logic [W-1:0] d;
    d = 8'hA5;
    launch(d, 1'b1, 1'b0);
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge CLK);
      vec_cnt++;
      if (mux_sel !== exp_mux(c, 1'b1) || busy !== exp_busy(c, 1'b1)) begin
        err_cnt++;
        $display("FAIL even c=%0d: mux=%b busy=%b, want %b %b", c, mux_sel, busy, exp_mux(c, 1'b1), exp_busy(c, 1'b1));
      end
      if (c >= 1 && c <= W) begin
        vec_cnt++;
        if (ser_data !== d[c-1]) begin
          err_cnt++;
          $display("FAIL even_ser bit%0d: got %b want %b", c - 1, ser_data, d[c-1]);
        end
      end
      vec_cnt++;
      if (par_bit !== 1'b0) begin
        err_cnt++;
        $display("FAIL even_par c=%0d: got %b want 0", c, par_bit);
      end
    end
  endtask

  task automatic test_odd_parity();
    logic [W-1:0] dv [2];
    logic         pv [2];
    dv[0] = 8'h03; pv[0] = 1'b1;
    dv[1] = 8'h07; pv[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      launch(dv[k], 1'b1, 1'b1);
      for (int c = 0; c <= W + 2; c++) begin
        @(negedge CLK);
        vec_cnt++;
        if (mux_sel !== exp_mux(c, 1'b1) || busy !== exp_busy(c, 1'b1)) begin
          err_cnt++;
          $display("FAIL odd%0d c=%0d: mux=%b busy=%b, want %b %b", k, c, mux_sel, busy, exp_mux(c, 1'b1), exp_busy(c, 1'b1));
        end
        if (c == W + 1) begin
          vec_cnt++;
          if (par_bit !== pv[k]) begin
            err_cnt++;
            $display("FAIL odd_par data=%h: got %b want %b", dv[k], par_bit, pv[k]);
          end
        end
      end
    end
  endtask

  task automatic test_no_parity();
    logic [W-1:0] d;
    d = 8'hFF;
    launch(d, 1'b0, 1'b0);
    for (int c = 0; c <= W + 2; c++) begin
      @(negedge CLK);
      vec_cnt++;
      if (mux_sel !== exp_mux(c, 1'b0) || busy !== exp_busy(c, 1'b0)) begin
        err_cnt++;
        $display("FAIL nopar c=%0d: mux=%b busy=%b, want %b %b", c, mux_sel, busy, exp_mux(c, 1'b0), exp_busy(c, 1'b0));
      end
      if (c >= 1 && c <= W) begin
        vec_cnt++;
        if (ser_data !== 1'b1) begin
          err_cnt++;
          $display("FAIL nopar_ser bit%0d: got %b want 1", c - 1, ser_data);
        end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [W-1:0] d;
    d = 8'hA5;
    launch(d, 1'b1, 1'b0);
    for (int c = 0; c <= W + 8; c++) begin
      @(negedge CLK);
      vec_cnt++;
      if (mux_sel !== exp_mux(c, 1'b1) || busy !== exp_busy(c, 1'b1)) begin
        err_cnt++;
        $display("FAIL ignore c=%0d: mux=%b busy=%b, want %b %b", c, mux_sel, busy, exp_mux(c, 1'b1), exp_busy(c, 1'b1));
      end
      if (c >= 1 && c <= W) begin
        vec_cnt++;
        if (ser_data !== d[c-1]) begin
          err_cnt++;
          $display("FAIL ignore_ser bit%0d: got %b want %b", c - 1, ser_data, d[c-1]);
        end
      end
      vec_cnt++;
      if (par_bit !== 1'b0) begin
        err_cnt++;
        $display("FAIL ignore_par c=%0d: got %b want 0", c, par_bit);
      end
      if (c == 3) begin
        DATA_VALID = 1'b1; P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b1;
      end
      if (c == 4) DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    int           fl;
    int           c2;
    fl = W + 3;
    @(posedge CLK); #1;
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'hAA;
    for (int c = 0; c <= 2 * fl + 1; c++) begin
      @(negedge CLK);
      c2 = (c < fl + 1) ? c : c - (fl + 1);
      d  = (c < fl + 1) ? 8'h55 : 8'hAA;
      vec_cnt++;
      if (mux_sel !== exp_mux(c2, 1'b1) || busy !== exp_busy(c2, 1'b1)) begin
        err_cnt++;
        $display("FAIL b2b c=%0d: mux=%b busy=%b, want %b %b", c, mux_sel, busy, exp_mux(c2, 1'b1), exp_busy(c2, 1'b1));
      end
      if (c2 >= 1 && c2 <= W) begin
        vec_cnt++;
        if (ser_data !== d[c2-1]) begin
          err_cnt++;
          $display("FAIL b2b_ser c=%0d: got %b want %b", c, ser_data, d[c2-1]);
        end
      end
      if (c == fl + 1) DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d;
    launch(8'hA5, 1'b1, 1'b0);
    for (int c = 0; c <= 4; c++) @(negedge CLK);
    vec_cnt++;
    if (mux_sel !== 2'b10 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_pre: mux=%b busy=%b, want 10 1", mux_sel, busy);
    end
    #1 RST = 1'b0;
    #1;
    vec_cnt++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_async: mux=%b busy=%b ser=%b par=%b, want 01 0 0 0", mux_sel, busy, ser_data, par_bit);
    end
    @(negedge CLK); @(negedge CLK); RST = 1'b1;
    d = 8'h81;
    launch(d, 1'b1, 1'b1);
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge CLK);
      vec_cnt++;
      if (mux_sel !== exp_mux(c, 1'b1) || busy !== exp_busy(c, 1'b1)) begin
        err_cnt++;
        $display("FAIL rst_frame c=%0d: mux=%b busy=%b, want %b %b", c, mux_sel, busy, exp_mux(c, 1'b1), exp_busy(c, 1'b1));
      end
      if (c >= 1 && c <= W) begin
        vec_cnt++;
        if (ser_data !== d[c-1]) begin
          err_cnt++;
          $display("FAIL rst_ser bit%0d: got %b want %b", c - 1, ser_data, d[c-1]);
        end
      end
      if (c == W + 1) begin
        vec_cnt++;
        if (par_bit !== 1'b1) begin
          err_cnt++;
          $display("FAIL rst_par: got %b want 1", par_bit);
        end
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
